// File: rtl/ssi_pkg.sv
// ssi_pkg: shared FSM state type and default parameters for the SSI encoder slave
package ssi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, MONO} ssi_state_t;
    localparam int SSI_DATA_WIDTH     = 18;
    localparam int SSI_SYNC_STAGES    = 2;
    localparam int SSI_TIMEOUT_CYCLES = 1000;
endpackage

// File: rtl/ssi_clk_sync.sv
// ssi_clk_sync: SSI clock synchronizer presetting to the idle-high level, with registered edge strobes
module ssi_clk_sync
    import ssi_pkg::*;
#(
    parameter int SYNC_STAGES = SSI_SYNC_STAGES
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic ssi_clk_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync  <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], ssi_clk_in};
            level <= sync[SYNC_STAGES-1];
            rise  <= sync[SYNC_STAGES-1] & ~level;
            fall  <= ~sync[SYNC_STAGES-1] & level;
        end
    end
endmodule

// File: rtl/ssi_encoder_slave.sv
// ssi_encoder_slave: SSI absolute-encoder emulator shifting a latched position out MSB-first.
// Define SSI_PARITY_EN to append an even-parity bit after the data bits.
module ssi_encoder_slave
    import ssi_pkg::*;
#(
    parameter int DATA_WIDTH     = SSI_DATA_WIDTH,
    parameter int SYNC_STAGES    = SSI_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = SSI_TIMEOUT_CYCLES
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] position_in,
    input  logic                  position_valid_in,
    input  logic                  ssi_clk_in,
    output logic                  ssi_data_out,
    output logic                  frame_busy_out,
    output logic                  frame_done_out,
    output logic                  frame_error_out
);
    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ssi_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, shadow_q, shadow_d, latch_word;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  data_q, data_d, done_q, done_d, error_q, error_d;
    logic                  level, rise, fall, timeout;
`ifdef SSI_PARITY_EN
    logic                  par_q, par_d;
`endif

    ssi_clk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ssi_clk_in(ssi_clk_in),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    // a load coinciding with the latch edge goes straight into the frame
    assign latch_word = position_valid_in ? position_in : hold_q;
    assign timeout    = state_q != IDLE && level && !rise && !fall && to_q == TW'(TIMEOUT_CYCLES - 1);
    assign to_d       = (state_q == IDLE || rise || fall || timeout) ? '0 : level ? to_q + TW'(1) : to_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
`ifdef SSI_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                data_d = 1'b1;
                if (fall) begin
                    shadow_d = latch_word;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef SSI_PARITY_EN
                    par_d    = ^latch_word;
`endif
                end
            end
            SHIFT: begin
                if (timeout) begin
                    error_d = 1'b1;
                    data_d  = 1'b1;
                    state_d = IDLE;
                end else if (rise) begin
                    if (cnt_q < BW'(DATA_WIDTH)) begin
                        data_d   = shadow_q[DATA_WIDTH-1];
                        shadow_d = shadow_q << 1;
                        cnt_d    = cnt_q + BW'(1);
                    end
`ifdef SSI_PARITY_EN
                    else if (cnt_q == BW'(DATA_WIDTH)) begin
                        data_d = par_q;
                        cnt_d  = cnt_q + BW'(1);
                    end
`endif
                    else begin
                        data_d  = 1'b1;
                        state_d = MONO;
                    end
                end
            end
            MONO: begin
                data_d = 1'b1;
                if (timeout) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            data_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef SSI_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= position_valid_in ? position_in : hold_q;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            data_q   <= data_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef SSI_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign ssi_data_out    = data_q;
    assign frame_busy_out  = state_q != IDLE;
    assign frame_done_out  = done_q;
    assign frame_error_out = error_q;
endmodule

// File: tb/tb_ssi_encoder_slave.sv
// tb_ssi_encoder_slave: randomized SSI master with a scoreboard monitor for ssi_encoder_slave.
// Honours SSI_PARITY_EN the same way as the design.
module tb_ssi_encoder_slave;
    localparam int NB = 18;
    localparam int SS = 2;
    localparam int TO = 1000;
    localparam int HP = 20;
`ifdef SSI_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          m;
        bit          err;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] position_in = '0;
    logic          position_valid_in = 1'b0;
    logic          ssi_clk = 1'b1;
    logic          ssi_data_out, frame_busy_out, frame_done_out, frame_error_out;
    logic [NB-1:0] hold = '0;
    exp_t          q[$];
    int            tests = 0;
    int            fails = 0;

    ssi_encoder_slave #(.DATA_WIDTH(NB), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk          (sys_clk),
        .reset            (reset),
        .position_in      (position_in),
        .position_valid_in(position_valid_in),
        .ssi_clk_in       (ssi_clk),
        .ssi_data_out     (ssi_data_out),
        .frame_busy_out   (frame_busy_out),
        .frame_done_out   (frame_done_out),
        .frame_error_out  (frame_error_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic half(input logic v);
        ssi_clk = v;
        tick(HP);
    endtask

    task automatic load(input logic [NB-1:0] v);
        position_in = v;
        position_valid_in = 1'b1;
        tick(1);
        position_valid_in = 1'b0;
        hold = v;
    endtask

    // Expected bit stream: word MSB-first, optional even parity, truncated to what nr rising edges reveal
    function automatic exp_t mk(input logic [NB-1:0] w, input int nr, input int nm);
        exp_t e;
        logic [31:0] s;
        int full;
        full = NB + P;
        s = 32'(w);
        if (P != 0) s = (s << 1) | 32'($countones(w) % 2);
        e.n = (nr - 1 < full) ? nr - 1 : full;
        e.bits = s >> (full - e.n);
        e.err = nr < full + 1;
        e.m = nm;
        return e;
    endfunction

    // One frame: latching fall, nr rising edges, nm extra low pulses, then idle high past the timeout
    task automatic send(input int nr, input int nm, input bit byp, input logic [NB-1:0] bv,
                        input int mid, input logic [NB-1:0] mv);
        q.push_back(mk(byp ? bv : hold, nr, nm));
        ssi_clk = 1'b0;
        if (byp) begin
            tick(SS + 1);
            position_in = bv;
            position_valid_in = 1'b1;
            tick(1);
            position_valid_in = 1'b0;
            hold = bv;
            tick(HP - SS - 2);
        end else tick(HP);
        chk("busy_in_frame", int'(frame_busy_out), 1);
        for (int i = 0; i < nr; i++) begin
            if (i > 0) half(1'b0);
            ssi_clk = 1'b1;
            if (i == mid) load(mv);
            tick(HP);
        end
        if (nr == NB + P + 1) chk("tail_high", int'(ssi_data_out), 1);
        for (int i = 0; i < nm; i++) begin
            half(1'b0);
            half(1'b1);
        end
        tick(TO + 40);
    endtask

    initial begin : monitor
        logic prev;
        int   k;
        logic smp[$];
        exp_t e;
        logic [31:0] got;
        bit   ones;
        prev = 1'b1;
        k = 0;
        forever begin
            @(negedge sys_clk);
            if (reset) begin
                smp.delete();
                prev = ssi_clk;
                k = 0;
            end else begin
                if (ssi_clk != prev) begin
                    k = 0;
                    if (!ssi_clk) smp.push_back(ssi_data_out);
                end else k++;
                prev = ssi_clk;
                if (frame_done_out || frame_error_out) begin
                    if (q.size() == 0) chk("unexpected_pulse", int'({frame_done_out, frame_error_out}), 0);
                    else begin
                        e = q.pop_front();
                        chk("pulse_is_error", int'(frame_error_out), int'(e.err));
                        chk("pulse_is_done", int'(frame_done_out), int'(!e.err));
                        chk("timeout_delay", k, TO + SS + 2);
                        chk("busy_at_pulse", int'(frame_busy_out), 0);
                        chk("data_at_pulse", int'(ssi_data_out), 1);
                        chk("sample_count", smp.size(), e.n + 1 + e.m);
                        if (smp.size() == e.n + 1 + e.m) begin
                            got = '0;
                            for (int i = 1; i <= e.n; i++) got = (got << 1) | 32'(smp[i]);
                            ones = smp[0];
                            for (int i = e.n + 1; i < smp.size(); i++) ones = ones & smp[i];
                            chk("frame_bits", int'(got), int'(e.bits));
                            chk("idle_high_samples", int'(ones), 1);
                        end
                    end
                    smp.delete();
                end
            end
        end
    end

    initial begin : stimulus
        logic [NB-1:0] w;
        tick(3);
        chk("reset_data", int'(ssi_data_out), 1);
        chk("reset_busy", int'(frame_busy_out), 0);
        chk("reset_done", int'(frame_done_out), 0);
        chk("reset_error", int'(frame_error_out), 0);
        reset = 1'b0;
        tick(2 * HP);
        load(18'h1a34f);
        send(NB + P + 1, 0, 1'b0, '0, -1, '0);
        send(NB + P + 1, 0, 1'b1, 18'h1fd3a, 5, 18'h00028);
        load(NB'($urandom));
        send(8, 0, 1'b0, '0, -1, '0);
        load(18'h3ffd8);
        send(NB + P + 1, 0, 1'b0, '0, -1, '0);
        load(18'h2b7c5);
        ssi_clk = 1'b0;
        tick(HP);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) half(1'b0);
            half(1'b1);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        hold = '0;
        chk("midreset_data", int'(ssi_data_out), 1);
        chk("midreset_busy", int'(frame_busy_out), 0);
        chk("midreset_pulses", int'({frame_done_out, frame_error_out}), 0);
        tick(TO + 40);
        send(NB + P + 1, 0, 1'b0, '0, -1, '0);
        load(NB'($urandom));
        send(NB + P + 1, 0, 1'b0, '0, -1, '0);
        load(18'h132f1);
        send(NB + P + 1, 0, 1'b0, '0, -1, '0);
        load(18'h00000);
        send(NB + P + 1, 3, 1'b0, '0, -1, '0);
        for (int r = 0; r < 4; r++) begin
            w = NB'($urandom);
            load(w);
            send(NB + P + 1, $urandom_range(0, 2), 1'b0, '0, -1, '0);
        end
        tick(10);
        chk("pending_frames", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1_500_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/ssi_encoder_slave.md
# ssi_encoder_slave

Synthesizable SSI absolute-encoder emulator: the slave/transmitter end of the serial position link whose master is the location control unit. It samples the master-driven SSI clock and shifts a latched multi-bit position value out MSB-first, with idle-high data and a monoflop timeout. It is used as a hardware-in-the-loop stand-in for the encoder on spare FPGA pins, and as a synthesizable loopback partner in system simulation.

## Interface
- DATA_WIDTH, 18: position word width in bits.
- SYNC_STAGES, 2: synchronizer depth on ssi_clk_in (minimum 2).
- TIMEOUT_CYCLES, 1000: monoflop time, in sys_clk cycles of continuous-high ssi_clk.
- sys_clk  in  1  system clock; all logic rises on it.
- reset  in  1  synchronous, active-high reset.
- position_in  in  DATA_WIDTH  position value to publish.
- position_valid_in  in  1  loads position_in into the holding register.
- ssi_clk_in  in  1  SSI clock from the master; asynchronous; idles high.
- ssi_data_out  out  1  SSI data line; idle high.
- frame_busy_out  out  1  high from latch until return to IDLE.
- frame_done_out  out  1  one-cycle pulse when a complete frame times out normally.
- frame_error_out  out  1  one-cycle pulse when a frame is aborted mid-shift by timeout.

## Operation
- Holding register: loaded on position_valid_in, reset value 0. If position_valid_in coincides with a latch event, the new position_in is latched directly (bypass).
- FSM states: IDLE, SHIFT, MONO.
- IDLE:
  - ssi_data_out = 1.
  - A synchronized falling edge latches the shadow register, clears bit_cnt, and moves to SHIFT. Data stays 1 until the first rising edge.
- SHIFT:
  - Each rising edge with bit_cnt < DATA_WIDTH drives shadow[DATA_WIDTH-1-bit_cnt], then increments bit_cnt.
  - The rising edge with bit_cnt == DATA_WIDTH (the tail edge) drives 1 and moves to MONO.
  - Falling edges in SHIFT only clear the timeout counter.
- MONO:
  - Data is held at 1. Falling edges are ignored (no re-latch, no multi-read repeat).
- Timeout counter:
  - Counts sys_clk cycles while the synchronized clock is high in SHIFT or MONO. It clears on any synchronized edge.
  - When it reaches TIMEOUT_CYCLES: from MONO, pulse frame_done_out; from SHIFT, pulse frame_error_out. In both cases go to IDLE with data = 1.
- Counter widths are sized with $clog2. bit_cnt never wraps and saturates at its terminal value.
- frame_busy_out = (state != IDLE).
- Reset, including mid-frame: state IDLE, ssi_data_out 1, busy/done/error 0, counters 0, shadow 0, synchronizer flops set to 1 (idle level). This prevents a false falling edge after reset.

## Timing
- A transition on ssi_clk_in is first captured at sync edge 0. The resulting action (latch, data change, state change) is registered SYNC_STAGES+1 sys_clk edges after edge 0.
- With the default SYNC_STAGES, that is 3 edges after edge 0.
- The ssi_clk half-period must be at least SYNC_STAGES+2 sys_clk cycles; faster clocks are unsupported.
- frame_done_out and frame_error_out assert on the same edge that the state returns to IDLE.
- With the default DATA_WIDTH, a full frame takes 19 rising edges: 18 data edges plus 1 tail edge.

## Configuration
- SSI_PARITY_EN defined: one even-parity bit over the shadow word is driven on rising edge DATA_WIDTH+1. Data goes high on rising edge DATA_WIDTH+2, then the block enters MONO.
- SSI_PARITY_EN undefined: no parity bit; the behaviour is exactly as described above.

## Structure
- Package ssi_pkg holds:
  - the ssi_state_t enum (IDLE, SHIFT, MONO);
  - default constants SSI_DATA_WIDTH = 18, SSI_SYNC_STAGES = 2, SSI_TIMEOUT_CYCLES = 1000.
- Sub-module ssi_clk_sync: SYNC_STAGES-deep synchronizer with preset-to-1 on reset, plus an output flop and registered-compare rise/fall strobes.
- The top level contains the FSM, shadow/holding registers, bit counter, and timeout counter.

## Test plan
- Load 18'h1a34f. The master issues 18 bits plus a tail edge at half-period 20. Required: the sampled bits equal 18'h1a34f MSB-first, data returns high at the tail edge, and frame_done_out pulses once, 1000 cycles after the last edge.
- position_valid_in with 18'h1fd3a on the same cycle the latch fires: the frame carries 18'h1fd3a. A later load of 18'h00028 mid-frame does not alter the frame in progress.
- The master stops high after 7 bits. Required: frame_error_out pulses after 1000 cycles, state is IDLE, data is 1, and a following frame of 18'h3ffd8 reads correctly.
- Assert reset at bit 9 of a frame. Required: the next cycle shows data 1 and busy 0, with no done/error pulse, and the next full frame reads the current holding value.
- With SSI_PARITY_EN defined, send 18'h132f1. Required: 18 data bits, then parity bit 1 (the word has nine ones) on edge 19, then data high on edge 20.
- Falling edges in MONO, within the timeout window, with 18'h00000 loaded: no re-latch occurs, data stays 1, and the done pulse is deferred until the clock has been high for 1000 cycles.
